// File: rtl/run_length_detector_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// run_length_detector_pkg : state and mode encodings   (rev 1.0)
// ------------------------------------------------------------------
package run_length_detector_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_SAT  = 2'b10;
    localparam logic [1:0] ST_ILL  = 2'b11;

    localparam logic MODE_PULSE = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_SAT  = ST_SAT,
        S_ILL  = ST_ILL
    } state_t;

endpackage
`default_nettype wire

// File: rtl/run_length_detector_if.sv
`default_nettype none
// ------------------------------------------------------------------
// run_length_detector_if : serial input and detector result bundle (rev 1.0)
// ------------------------------------------------------------------
interface run_length_detector_if #(
    parameter int CNT_W = 4
);
    logic             en;
    logic             x;
    logic             mode;
    logic [CNT_W-1:0] thr_i;
    logic             clr;
    logic             y;
    logic [CNT_W-1:0] run_len;
    logic             len_vld;
    logic             sat_flag;
    logic [1:0]       state;

    modport master (
        output en, x, mode, thr_i, clr,
        input  y, run_len, len_vld, sat_flag, state
    );

    modport slave (
        input  en, x, mode, thr_i, clr,
        output y, run_len, len_vld, sat_flag, state
    );
endinterface
`default_nettype wire

// File: rtl/run_length_detector_sat_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// run_length_detector_sat_counter : saturating up-counter, sync clear (rev 1.0)
// ------------------------------------------------------------------
module run_length_detector_sat_counter #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] count,
    output logic                  at_max
);
    localparam logic [CNT_W-1:0] C_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count  = r_count;
    assign at_max = (r_count == C_MAX);
endmodule
`default_nettype wire

// File: rtl/run_length_detector.sv
`default_nettype none
// ------------------------------------------------------------------
// run_length_detector : run-of-ones length detector with threshold (rev 1.0)
// ------------------------------------------------------------------
module run_length_detector
    import run_length_detector_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int RST_THR = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    run_length_detector_if.slave bus
);
    localparam logic [CNT_W-1:0] C_MAX     = '1;
    localparam logic [CNT_W-1:0] C_RST_THR = CNT_W'(RST_THR);

    state_t           r_state;
    logic             r_y;
    logic [CNT_W-1:0] r_run_len;
    logic             r_len_vld;
    logic             r_sat_flag;

    logic [CNT_W-1:0] w_cnt;
    logic             w_at_max;
    logic [CNT_W-1:0] w_thr;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_inc;
    logic             w_clear;
    logic             w_end;

    assign w_thr      = (bus.thr_i == '0) ? C_RST_THR : bus.thr_i;
    // Count value after consuming a 1; held at MAX once saturated.
    assign w_cnt_next = w_at_max ? w_cnt : (w_cnt + 1'b1);
    assign w_inc      = bus.en & bus.x & (r_state != S_ILL);
    assign w_clear    = (bus.en & ~bus.x) | (r_state == S_ILL);
    assign w_end      = bus.en & ~bus.x & ((r_state == S_RUN) | (r_state == S_SAT));

    run_length_detector_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clear),
        .inc    (w_inc),
        .count  (w_cnt),
        .at_max (w_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_y        <= 1'b0;
            r_run_len  <= '0;
            r_len_vld  <= 1'b0;
            r_sat_flag <= 1'b0;
        end else begin
            r_len_vld <= 1'b0;
            if (bus.clr) begin
                r_sat_flag <= 1'b0;
            end
            if (r_state == S_ILL) begin
                r_state <= S_IDLE;
                r_y     <= 1'b0;
            end else if (bus.en) begin
                if (bus.x) begin
                    r_state <= (w_cnt_next == C_MAX) ? S_SAT : S_RUN;
                    // A later assignment here takes priority over clr above.
                    if ((w_cnt_next == C_MAX) && (r_state != S_SAT)) begin
                        r_sat_flag <= 1'b1;
                    end
                    r_y <= (bus.mode == MODE_LEVEL) && (w_cnt_next >= w_thr);
                end else begin
                    r_state <= S_IDLE;
                    if (w_end) begin
                        r_run_len <= w_cnt;
                        r_len_vld <= 1'b1;
                    end
                    r_y <= (bus.mode == MODE_PULSE) && w_end && (w_cnt >= w_thr);
                end
            end else if (bus.mode == MODE_PULSE) begin
                r_y <= 1'b0;
            end
        end
    end

    assign bus.y        = r_y;
    assign bus.run_len  = r_run_len;
    assign bus.len_vld  = r_len_vld;
    assign bus.sat_flag = r_sat_flag;
    assign bus.state    = r_state;
endmodule
`default_nettype wire

// File: tb/tb_run_length_detector.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_run_length_detector : directed bench with run-length reference model (rev 1.0)
// ------------------------------------------------------------------
module tb_run_length_detector;
    localparam int CNT_W   = 4;
    localparam int RST_THR = 2;
    localparam int MAX     = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_on;

    run_length_detector_if #(.CNT_W(CNT_W)) bus ();

    run_length_detector #(
        .CNT_W   (CNT_W),
        .RST_THR (RST_THR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: tracks the run as an unbounded integer and derives outputs.
    int   m_run;
    logic m_y;
    int   m_len;
    logic m_vld;
    logic m_sat;
    int   m_state;

    always @(posedge clk) begin
        int  t;
        int  lc;
        bit  set_sat;
        if (rst) begin
            m_run = 0; m_y = 0; m_len = 0; m_vld = 0; m_sat = 0; m_state = 0;
        end else begin
            t       = (bus.thr_i == 0) ? RST_THR : int'(bus.thr_i);
            set_sat = 0;
            m_vld   = 0;
            if (bus.en) begin
                if (bus.x) begin
                    m_run   = m_run + 1;
                    lc      = (m_run > MAX) ? MAX : m_run;
                    set_sat = (m_run == MAX);
                    m_state = (m_run >= MAX) ? 2 : 1;
                    m_y     = bus.mode ? (lc >= t) : 1'b0;
                end else begin
                    lc = (m_run > MAX) ? MAX : m_run;
                    if (m_run > 0) begin
                        m_len = lc;
                        m_vld = 1;
                    end
                    m_y     = (!bus.mode && m_run > 0) ? (lc >= t) : 1'b0;
                    m_run   = 0;
                    m_state = 0;
                end
            end else if (!bus.mode) begin
                m_y = 0;
            end
            if (set_sat)      m_sat = 1;
            else if (bus.clr) m_sat = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_y",        32'(bus.y),        32'(m_y));
            chk("model_run_len",  32'(bus.run_len),  32'(m_len));
            chk("model_len_vld",  32'(bus.len_vld),  32'(m_vld));
            chk("model_sat_flag", 32'(bus.sat_flag), 32'(m_sat));
            chk("model_state",    32'(bus.state),    32'(m_state));
        end
    end

    // Apply one sample at a negedge; returns at the next negedge with outputs settled.
    task automatic cyc(input logic e, input logic xv, input logic m, input int thr, input logic c);
        bus.en    = e;
        bus.x     = xv;
        bus.mode  = m;
        bus.thr_i = CNT_W'(thr);
        bus.clr   = c;
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input int y, input int len, input int vld,
                           input int sat, input int st);
        chk({name, "_y"},       32'(bus.y),        32'(y));
        chk({name, "_run_len"}, 32'(bus.run_len),  32'(len));
        chk({name, "_len_vld"}, 32'(bus.len_vld),  32'(vld));
        chk({name, "_sat"},     32'(bus.sat_flag), 32'(sat));
        chk({name, "_state"},   32'(bus.state),    32'(st));
    endtask

    initial begin
        logic [39:0] pat;
        checks   = 0;
        failures = 0;
        chk_on   = 0;
        rst      = 1'b1;
        bus.en = 0; bus.x = 0; bus.mode = 0; bus.thr_i = '0; bus.clr = 0;
        cyc(0, 0, 0, 0, 0);
        chk_on = 1;
        cyc(1, 1, 0, 1, 0);
        chk_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Legacy end-of-ones behaviour, T=1
        cyc(1, 0, 0, 1, 0);  chk_out("t1_s0", 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);  chk_out("t1_s1", 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 1, 0);  chk_out("t1_s2", 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0);  chk_out("t1_end", 1, 2, 1, 0, 0);

        // Threshold 3 in pulse mode
        cyc(1, 1, 0, 3, 0); cyc(1, 1, 0, 3, 0);
        cyc(1, 0, 0, 3, 0);  chk_out("t3_short", 0, 2, 1, 0, 0);
        cyc(1, 1, 0, 3, 0); cyc(1, 1, 0, 3, 0); cyc(1, 1, 0, 3, 0);
        cyc(1, 0, 0, 3, 0);  chk_out("t3_long", 1, 3, 1, 0, 0);

        // Level mode, threshold 2
        cyc(1, 1, 1, 2, 0);  chk("lvl_y1", 32'(bus.y), 32'd0);
        cyc(1, 1, 1, 2, 0);  chk("lvl_y2", 32'(bus.y), 32'd1);
        cyc(1, 1, 1, 2, 0);  chk("lvl_y3", 32'(bus.y), 32'd1);
        cyc(1, 0, 1, 2, 0);  chk_out("lvl_end", 0, 3, 1, 0, 0);

        // Saturation: clr with the 15th one loses to the set
        for (int i = 1; i <= 17; i++) begin
            cyc(1, 1, 0, 1, (i == 15) || (i == 16));
            if (i == 14) chk_out("sat_14", 0, 3, 0, 0, 1);
            if (i == 15) chk_out("sat_15", 0, 3, 0, 1, 2);
            if (i == 16) chk("sat_clr", 32'(bus.sat_flag), 32'd0);
            if (i == 17) chk("sat_hold", 32'(bus.state), 32'd2);
        end
        cyc(1, 0, 0, 1, 0);  chk_out("sat_end", 1, 15, 1, 0, 0);

        // Enable gating
        cyc(1, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, i[0], 0, 1, 0);
            chk_out("en_off", 0, 15, 0, 0, 1);
        end
        cyc(1, 0, 0, 1, 0);  chk_out("en_end", 1, 2, 1, 0, 0);
        cyc(1, 1, 1, 1, 0);  chk("lvl_en_y", 32'(bus.y), 32'd1);
        cyc(0, 0, 1, 1, 0);  chk("lvl_hold_y", 32'(bus.y), 32'd1);
        cyc(1, 0, 1, 1, 0);  chk_out("lvl_hold_end", 0, 1, 1, 0, 0);

        // thr_i=0 selects RST_THR=2
        cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        chk_out("thr0_len1", 0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        chk_out("thr0_len2", 1, 2, 1, 0, 0);

        // Reset mid-run
        cyc(1, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0);
        rst = 1'b1;
        cyc(1, 1, 0, 1, 0);  chk_out("rst_mid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(1, 0, 0, 1, 0);  chk_out("rst_after", 0, 0, 0, 0, 0);

        // Mixed pattern with mode/threshold changes mid-run, checked by the model
        pat = 40'b1101_1110_0111_1101_0110_1111_1011_0001_1110_1010;
        for (int i = 0; i < 40; i++) begin
            cyc((i % 7) != 3, pat[i], (i / 10) % 2 == 1, (i / 5) % 4, (i % 11) == 0);
        end

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
